run_monitor: RTL and testbench
==============================

RUN_MONITOR -- requirements
Module: run_monitor

Interface
REQ-001 SHALL provide parameter PC_W, default 32, PC width in bits.
REQ-002 SHALL provide parameter NSTOP, default 2, number of stop-address comparators (1..4).
REQ-003 SHALL provide parameter CNT_W, default 16, retired-instruction counter width.
REQ-004 SHALL provide parameter NREG, default 32, registers dumped; REG_AW = clog2(NREG).
REQ-005 SHALL have port clk  in  1  single clock; all state changes on rising edge.
REQ-006 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-007 SHALL have port pc  in  PC_W  PC of the instruction retiring this cycle.
REQ-008 SHALL have port pc_valid  in  1  one instruction retires this cycle.
REQ-009 SHALL have port stop_addr  in  NSTOP*PC_W  packed stop addresses; slot i at bits [i*PC_W +: PC_W].
REQ-010 SHALL have port stop_en  in  NSTOP  per-slot comparator enable.
REQ-011 SHALL have port cyc_limit  in  CNT_W  retire-count timeout; 0 disables the timeout.
REQ-012 SHALL have port reg_sel  out  REG_AW  register-file read address for debug read.
REQ-013 SHALL have port reg_data  in  32  combinational register-file read data for reg_sel.
REQ-014 SHALL have ports dump_valid out 1, dump_ready in 1, dump_data out 32, dump_idx out REG_AW, dump_last out 1  register dump stream.
REQ-015 SHALL have port halt  out  1  CPU stall request.
REQ-016 SHALL have ports done out 1, halt_cause out 2, hit_idx out 2, retire_cnt out CNT_W  status.

Function
REQ-017 SHALL implement states RUN, DUMP, DONE; reset state RUN.
REQ-018 RUN: retire_cnt SHALL increment on each cycle with pc_valid=1, saturating at 2^CNT_W-1.
REQ-019 RUN: stop hit SHALL be pc_valid=1 and pc==stop_addr slot i with stop_en[i]=1; lowest matching i SHALL load hit_idx.
REQ-020 RUN: timeout SHALL be pc_valid=1, cyc_limit!=0 and retire_cnt+1 >= cyc_limit (post-increment count reaches limit).
REQ-021 halt_cause SHALL load 01 on stop hit only, 10 on timeout only, 11 when both occur in the same cycle; state SHALL go RUN->DUMP on either.
REQ-022 halt SHALL be 0 in RUN and 1 in DUMP and DONE (registered; asserts the cycle after the triggering retire).
REQ-023 retire_cnt SHALL include the triggering instruction and freeze outside RUN; pc_valid outside RUN SHALL be ignored.
REQ-024 DUMP: a registered index SHALL start at 0; reg_sel SHALL equal the index; dump_idx SHALL equal the index.
REQ-025 DUMP: dump_valid SHALL be 1; dump_data SHALL be reg_data, except index 0 SHALL report 32'h0 regardless of reg_data.
REQ-026 dump_data/dump_idx SHALL stay stable while dump_valid=1 and dump_ready=0; the index SHALL advance only on dump_valid&dump_ready.
REQ-027 dump_last SHALL be 1 exactly when index==NREG-1 in DUMP; a handshake there SHALL move DUMP->DONE.
REQ-028 DONE: dump_valid=0, halt=1, done=1; state SHALL persist until rst.
REQ-029 Dump throughput SHALL be one register per cycle with dump_ready held 1 (NREG cycles in DUMP).
REQ-030 Outside DUMP, reg_sel SHALL be 0 and dump_data, dump_idx, dump_last SHALL be 0.

Reset
REQ-031 rst=1 at a rising edge SHALL force state RUN, index 0, retire_cnt 0, halt_cause 00, hit_idx 0, halt 0, done 0, dump_valid 0.
REQ-032 rst SHALL take priority over every event in the same cycle, including a stop hit or a dump handshake.
REQ-033 rst asserted mid-DUMP SHALL abort the dump; no further dump_valid until a new halt event.

Verification
REQ-034 stop_addr slot0=32'h48, stop_en=01, cyc_limit=0, sequential PCs 0,4,..,0x48 valid each cycle -> halt_cause=01, hit_idx=0, retire_cnt=19, halt=1 next cycle.
REQ-035 cyc_limit=1000, stop_en=00, pc_valid=1 continuously -> halt_cause=10 with retire_cnt=1000; retire_cnt then frozen.
REQ-036 slot0=slot1=32'h20, both enabled, cyc_limit=9, PC 0x20 as 9th retire -> halt_cause=11, hit_idx=0.
REQ-037 In DUMP, drive reg_data=32'hA5A5_0000+reg_sel, toggle dump_ready 1/0 -> 32 beats, idx 0..31, beat0 data 0, beat7 data 32'hA5A5_0007, dump_last only on idx 31, then done=1.
REQ-038 rst pulse at DUMP index 10 -> next cycle halt=0, dump_valid=0, retire_cnt=0; a later stop hit restarts dump at idx 0.
REQ-039 Run with NSTOP=4, CNT_W=8, NREG=16: hit on slot 3 -> hit_idx=3; 16 beats, dump_last on idx 15; timeout at cyc_limit=255 -> retire_cnt=255.

Source files
------------

// File: rtl/run_monitor.sv
// rtl/run_monitor.sv - run monitor: halts the CPU on a stop address or retire-count
// timeout, then streams out the register file once and parks in DONE.
module run_monitor #(
  parameter  int PC_W   = 32,
  parameter  int NSTOP  = 2,
  parameter  int CNT_W  = 16,
  parameter  int NREG   = 32,
  localparam int REG_AW = $clog2(NREG)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PC_W-1:0]       pc,
  input  logic                  pc_valid,
  input  logic [NSTOP*PC_W-1:0] stop_addr,
  input  logic [NSTOP-1:0]      stop_en,
  input  logic [CNT_W-1:0]      cyc_limit,
  output logic [REG_AW-1:0]     reg_sel,
  input  logic [31:0]           reg_data,
  output logic                  dump_valid,
  input  logic                  dump_ready,
  output logic [31:0]           dump_data,
  output logic [REG_AW-1:0]     dump_idx,
  output logic                  dump_last,
  output logic                  halt,
  output logic                  done,
  output logic [1:0]            halt_cause,
  output logic [1:0]            hit_idx,
  output logic [CNT_W-1:0]      retire_cnt
);

  typedef enum logic [1:0] {S_RUN, S_DUMP, S_DONE} state_t;

  localparam logic [REG_AW-1:0] LAST_IDX = REG_AW'(NREG - 1);

  state_t            state, state_nxt;
  logic [REG_AW-1:0] idx, idx_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt, cnt_sat;
  logic [CNT_W:0]    cnt_inc;
  logic [1:0]        cause, cause_nxt;
  logic [1:0]        hit, hit_nxt;
  logic              stop_hit, timeout;
  logic [1:0]        stop_idx;

  // Scan from the top slot down so the lowest matching slot wins.
  always_comb begin
    stop_hit = 1'b0;
    stop_idx = 2'd0;
    for (int i = NSTOP - 1; i >= 0; i--) begin
      if (stop_en[i] && (stop_addr[i*PC_W +: PC_W] == pc)) begin
        stop_hit = 1'b1;
        stop_idx = 2'(i);
      end
    end
  end

  // Timeout compares the post-increment count, one bit wider so it cannot wrap.
  assign cnt_inc = {1'b0, cnt} + (CNT_W+1)'(1);
  assign cnt_sat = (&cnt) ? cnt : cnt + 1'b1;
  assign timeout = (cyc_limit != '0) && (cnt_inc >= {1'b0, cyc_limit});

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    cause_nxt = cause;
    hit_nxt   = hit;
    case (state)
      S_RUN: begin
        if (pc_valid) begin
          cnt_nxt = cnt_sat;
          if (stop_hit || timeout) begin
            cause_nxt = {timeout, stop_hit};
            if (stop_hit) hit_nxt = stop_idx;
            idx_nxt   = '0;
            state_nxt = S_DUMP;
          end
        end
      end
      S_DUMP: begin
        if (dump_ready) begin
          if (idx == LAST_IDX) state_nxt = S_DONE;
          else                 idx_nxt   = idx + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_RUN;
      idx   <= '0;
      cnt   <= '0;
      cause <= 2'b00;
      hit   <= 2'd0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      cnt   <= cnt_nxt;
      cause <= cause_nxt;
      hit   <= hit_nxt;
    end
  end

  // Register 0 is hardwired zero, so its beat never trusts the read port.
  assign dump_valid = (state == S_DUMP);
  assign reg_sel    = dump_valid ? idx : '0;
  assign dump_idx   = dump_valid ? idx : '0;
  assign dump_last  = dump_valid && (idx == LAST_IDX);
  assign dump_data  = (dump_valid && (idx != '0)) ? reg_data : 32'h0;
  assign halt       = (state != S_RUN);
  assign done       = (state == S_DONE);
  assign halt_cause = cause;
  assign hit_idx    = hit;
  assign retire_cnt = cnt;

endmodule

// File: tb/tb_run_monitor.sv
// tb/tb_run_monitor.sv - randomized and directed bench for run_monitor against a
// behavioural model, plus a small directed pass on a 4-slot / 8-bit / 16-reg instance.
module tb_run_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic [31:0] pc = '0;
  logic        pc_valid = 1'b0;
  logic [63:0] stop_addr = '0;
  logic [1:0]  stop_en = '0;
  logic [15:0] cyc_limit = '0;
  logic [4:0]  reg_sel;
  logic [31:0] reg_data;
  logic        dump_valid;
  logic        dump_ready = 1'b0;
  logic [31:0] dump_data;
  logic [4:0]  dump_idx;
  logic        dump_last, halt, done;
  logic [1:0]  halt_cause, hit_idx;
  logic [15:0] retire_cnt;
  logic [31:0] salt = 32'hA5A5_0000;

  logic         rst1 = 1'b1;
  logic [31:0]  pc1 = '0;
  logic         pc_valid1 = 1'b0;
  logic [127:0] stop_addr1 = '0;
  logic [3:0]   stop_en1 = '0;
  logic [7:0]   cyc_limit1 = '0;
  logic [3:0]   reg_sel1;
  logic [31:0]  reg_data1;
  logic         dump_valid1;
  logic         dump_ready1 = 1'b0;
  logic [31:0]  dump_data1;
  logic [3:0]   dump_idx1;
  logic         dump_last1, halt1, done1;
  logic [1:0]   halt_cause1, hit_idx1;
  logic [7:0]   retire_cnt1;

  assign reg_data  = salt + {27'd0, reg_sel};
  assign reg_data1 = salt + {28'd0, reg_sel1};

  run_monitor u_dut (
    .clk(clk), .rst(rst), .pc(pc), .pc_valid(pc_valid), .stop_addr(stop_addr),
    .stop_en(stop_en), .cyc_limit(cyc_limit), .reg_sel(reg_sel), .reg_data(reg_data),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_data(dump_data),
    .dump_idx(dump_idx), .dump_last(dump_last), .halt(halt), .done(done),
    .halt_cause(halt_cause), .hit_idx(hit_idx), .retire_cnt(retire_cnt)
  );

  run_monitor #(.PC_W(32), .NSTOP(4), .CNT_W(8), .NREG(16)) u_dut1 (
    .clk(clk), .rst(rst1), .pc(pc1), .pc_valid(pc_valid1), .stop_addr(stop_addr1),
    .stop_en(stop_en1), .cyc_limit(cyc_limit1), .reg_sel(reg_sel1), .reg_data(reg_data1),
    .dump_valid(dump_valid1), .dump_ready(dump_ready1), .dump_data(dump_data1),
    .dump_idx(dump_idx1), .dump_last(dump_last1), .halt(halt1), .done(done1),
    .halt_cause(halt_cause1), .hit_idx(hit_idx1), .retire_cnt(retire_cnt1)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Model: phase 0 running, 1 dumping, 2 finished.
  int       m_phase = 0, m_cnt = 0, m_idx = 0, m_hit_slot;
  bit       m_to;
  logic [1:0] m_cause = 0, m_hit = 0;
  bit       checking = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0; m_cnt = 0; m_idx = 0; m_cause = 0; m_hit = 0;
    end else if (m_phase == 0) begin
      if (pc_valid) begin
        m_hit_slot = -1;
        for (int i = 0; i < 2; i++)
          if (m_hit_slot < 0 && stop_en[i] && stop_addr[i*32 +: 32] == pc) m_hit_slot = i;
        m_to  = (cyc_limit != 0) && ((m_cnt + 1) >= cyc_limit);
        m_cnt = (m_cnt >= 65535) ? 65535 : m_cnt + 1;
        if (m_hit_slot >= 0 || m_to) begin
          m_cause = {m_to, m_hit_slot >= 0};
          if (m_hit_slot >= 0) m_hit = 2'(m_hit_slot);
          m_phase = 1;
          m_idx   = 0;
        end
      end
    end else if (m_phase == 1) begin
      if (dump_ready) begin
        if (m_idx == 31) m_phase = 2;
        else             m_idx++;
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      chk("halt", halt, m_phase != 0);
      chk("done", done, m_phase == 2);
      chk("dump_valid", dump_valid, m_phase == 1);
      chk("reg_sel", reg_sel, (m_phase == 1) ? m_idx : 0);
      chk("dump_idx", dump_idx, (m_phase == 1) ? m_idx : 0);
      chk("dump_last", dump_last, (m_phase == 1) && (m_idx == 31));
      chk("dump_data", dump_data, (m_phase == 1 && m_idx != 0) ? salt + m_idx : 32'h0);
      chk("retire_cnt", retire_cnt, m_cnt);
      chk("halt_cause", halt_cause, m_cause);
      chk("hit_idx", hit_idx, m_hit);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1; pc_valid = 1'b0; dump_ready = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic retire(input logic [31:0] a);
    pc = a; pc_valid = 1'b1;
    step();
    pc_valid = 1'b0;
  endtask

  int beats, c, nlast, lastidx;

  initial begin
    step();
    checking = 1;
    rst = 1'b0;
    #1;
    chk("reset_halt", halt, 0);
    chk("reset_cnt", retire_cnt, 0);
    chk("reset_valid", dump_valid, 0);

    // Stop on slot 0 after 19 sequential retires, then a throttled dump.
    stop_addr = {32'h0, 32'h48}; stop_en = 2'b01; cyc_limit = 0;
    for (int k = 0; k <= 18; k++) begin
      retire(32'(k * 4));
      if (k == 17) begin #1; chk("stop_not_yet", halt, 0); end
    end
    #1;
    chk("stop_cause", halt_cause, 2'b01);
    chk("stop_hit_idx", hit_idx, 0);
    chk("stop_cnt", retire_cnt, 19);
    chk("stop_halt", halt, 1);
    beats = 0; c = 0;
    while (!done && c < 200) begin
      dump_ready = ~c[0];
      #1;
      if (dump_valid && dump_ready) begin
        chk("beat_idx", dump_idx, beats);
        if (beats == 0) chk("beat0_data", dump_data, 32'h0);
        if (beats == 7) chk("beat7_data", dump_data, 32'hA5A5_0007);
        chk("beat_last", dump_last, beats == 31);
        beats++;
      end
      step();
      c++;
    end
    chk("dump_beats", beats, 32);
    chk("dump_done", done, 1);
    dump_ready = 0;

    // Timeout at 1000 retires, count frozen afterwards, full-rate dump.
    do_reset();
    stop_en = 2'b00; cyc_limit = 1000; pc_valid = 1;
    c = 0;
    while (!halt && c < 1100) begin pc = $urandom; step(); c++; end
    #1;
    chk("to_cause", halt_cause, 2'b10);
    chk("to_cnt", retire_cnt, 1000);
    repeat (5) step();
    #1;
    chk("to_frozen", retire_cnt, 1000);
    dump_ready = 1; c = 0;
    while (!done && c < 100) begin step(); c++; end
    chk("dump_rate", c, 32);
    pc_valid = 0; dump_ready = 0;

    // Stop and timeout on the same retire.
    do_reset();
    stop_addr = {32'h20, 32'h20}; stop_en = 2'b11; cyc_limit = 9;
    for (int k = 0; k < 8; k++) retire(32'h100 + 32'(k * 4));
    retire(32'h20);
    #1;
    chk("both_cause", halt_cause, 2'b11);
    chk("both_hit_idx", hit_idx, 0);
    chk("both_cnt", retire_cnt, 9);

    // Reset in the middle of a dump aborts it; a new hit restarts at index 0.
    do_reset();
    stop_addr = {32'h0, 32'h48}; stop_en = 2'b01; cyc_limit = 0;
    retire(32'h48);
    dump_ready = 1; c = 0;
    while (dump_idx != 10 && c < 50) begin step(); c++; end
    rst = 1;
    step();
    rst = 0;
    #1;
    chk("abort_halt", halt, 0);
    chk("abort_valid", dump_valid, 0);
    chk("abort_cnt", retire_cnt, 0);
    repeat (3) step();
    #1;
    chk("abort_quiet", dump_valid, 0);
    retire(32'h48);
    #1;
    chk("restart_valid", dump_valid, 1);
    chk("restart_idx", dump_idx, 0);
    c = 0;
    while (!done && c < 100) begin step(); c++; end
    chk("restart_done", done, 1);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 4000; n++) begin
      rst = ($urandom_range(0, 199) == 0) || (done && $urandom_range(0, 9) == 0);
      if (rst) begin
        stop_addr = {32'($urandom_range(0, 7) * 4), 32'($urandom_range(0, 7) * 4)};
        stop_en   = 2'($urandom_range(0, 3));
        cyc_limit = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 40));
        salt      = $urandom;
      end
      pc_valid   = $urandom_range(0, 3) != 0;
      pc         = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 15) * 4);
      dump_ready = $urandom_range(0, 1);
      step();
    end
    rst = 0; pc_valid = 0; dump_ready = 0; salt = 32'hA5A5_0000;

    // Four slots, 8-bit counter, 16 registers.
    rst1 = 1; step(); rst1 = 0;
    stop_addr1 = {32'h30, 32'h50, 32'h60, 32'h70}; stop_en1 = 4'b1111; cyc_limit1 = 0;
    pc1 = 32'h30; pc_valid1 = 1; step(); pc_valid1 = 0;
    #1;
    chk("w_hit_idx", hit_idx1, 3);
    chk("w_cause", halt_cause1, 2'b01);
    dump_ready1 = 1; beats = 0; nlast = 0; lastidx = 0; c = 0;
    while (!done1 && c < 60) begin
      #1;
      if (dump_valid1 && dump_ready1) begin
        if (dump_last1) begin nlast++; lastidx = dump_idx1; end
        if (beats == 5) chk("w_beat5_data", dump_data1, 32'hA5A5_0005);
        beats++;
      end
      step();
      c++;
    end
    chk("w_beats", beats, 16);
    chk("w_nlast", nlast, 1);
    chk("w_lastidx", lastidx, 15);
    dump_ready1 = 0;
    rst1 = 1; step(); rst1 = 0;
    stop_en1 = 0; cyc_limit1 = 255; pc_valid1 = 1; c = 0;
    while (!halt1 && c < 300) begin step(); c++; end
    #1;
    chk("w_to_cnt", retire_cnt1, 255);
    chk("w_to_cause", halt_cause1, 2'b10);
    rst1 = 1; step(); rst1 = 0;
    cyc_limit1 = 0;
    repeat (300) step();
    #1;
    chk("w_sat_cnt", retire_cnt1, 255);
    chk("w_sat_halt", halt1, 0);
    pc_valid1 = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
